// File: rtl/ram_loader_pkg.sv
// Shared types and constants for the RAM loader.
//   loader_state_e  : loader FSM state encoding
//   DefaultSyncByte : default frame start marker
package ram_loader_pkg;

  localparam logic [7:0] DefaultSyncByte = 8'hA5;

  typedef enum logic [2:0] {
    StIdle,
    StAddr,
    StLen,
    StData,
    StCsum,
    StDone,
    StError
  } loader_state_e;

endpackage

// File: rtl/ram_loader_if.sv
// Byte stream valid/ready channel feeding the RAM loader.
//   s_valid : upstream byte valid
//   s_data  : upstream byte
//   s_ready : consumer accepts a byte this cycle
// master = byte source, slave = loader.
interface ram_loader_if;

  logic       s_valid;
  logic [7:0] s_data;
  logic       s_ready;

  modport master (
    output s_valid,
    output s_data,
    input  s_ready
  );

  modport slave (
    input  s_valid,
    input  s_data,
    output s_ready
  );

endinterface

// File: rtl/ram_loader.sv
// Byte-stream loader for the 256-byte RAM write port.
// Accepts frames of SYNC_BYTE, address, length (0 = 256), payload, checksum,
// writes the payload to RAM and reports done (checksum good) or err (bad).
//   clk, rst_n        : clock, synchronous active-low reset
//   s (slave)         : valid/ready byte input
//   ack               : clears done/err and returns to idle
//   ram_we/addr/din   : registered RAM write port, one pulse per payload byte
//   busy, done, err   : registered frame status
module ram_loader
  import ram_loader_pkg::*;
#(
  parameter logic [7:0] SYNC_BYTE = DefaultSyncByte
) (
  input  logic        clk,
  input  logic        rst_n,
  ram_loader_if.slave s,
  input  logic        ack,
  output logic        ram_we,
  output logic [7:0]  ram_addr,
  output logic [7:0]  ram_din,
  output logic        busy,
  output logic        done,
  output logic        err
);

  loader_state_e state_q;
  logic [7:0]    ptr_q;
  logic [8:0]    cnt_q;
  logic [7:0]    sum_q;

  logic       fire;
  logic [7:0] sum_next;

  // Ready is a pure state decode so it never combinationally depends on s_valid.
  assign s.s_ready = (state_q != StDone) && (state_q != StError);
  assign fire      = s.s_valid && s.s_ready;
  assign sum_next  = sum_q + s.s_data;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q  <= StIdle;
      ptr_q    <= 8'h00;
      cnt_q    <= 9'd0;
      sum_q    <= 8'h00;
      ram_we   <= 1'b0;
      ram_addr <= 8'h00;
      ram_din  <= 8'h00;
      busy     <= 1'b0;
      done     <= 1'b0;
      err      <= 1'b0;
    end else begin
      // Write enable is a single-cycle pulse; address/data hold otherwise.
      ram_we <= 1'b0;
      unique case (state_q)
        StIdle: begin
          if (fire && (s.s_data == SYNC_BYTE)) begin
            state_q <= StAddr;
            sum_q   <= 8'h00;
            busy    <= 1'b1;
          end
        end
        StAddr: begin
          if (fire) begin
            ptr_q   <= s.s_data;
            sum_q   <= sum_next;
            state_q <= StLen;
          end
        end
        StLen: begin
          if (fire) begin
            cnt_q   <= (s.s_data == 8'h00) ? 9'd256 : {1'b0, s.s_data};
            sum_q   <= sum_next;
            state_q <= StData;
          end
        end
        StData: begin
          if (fire) begin
            ram_we   <= 1'b1;
            ram_addr <= ptr_q;
            ram_din  <= s.s_data;
            ptr_q    <= ptr_q + 8'h01;
            cnt_q    <= cnt_q - 9'd1;
            sum_q    <= sum_next;
            if (cnt_q == 9'd1) begin
              state_q <= StCsum;
            end
          end
        end
        StCsum: begin
          if (fire) begin
            sum_q <= sum_next;
            busy  <= 1'b0;
            if (sum_next == 8'h00) begin
              state_q <= StDone;
              done    <= 1'b1;
            end else begin
              state_q <= StError;
              err     <= 1'b1;
            end
          end
        end
        StDone, StError: begin
          if (ack) begin
            state_q <= StIdle;
            done    <= 1'b0;
            err     <= 1'b0;
          end
        end
        default: begin
          state_q <= StIdle;
          busy    <= 1'b0;
          done    <= 1'b0;
          err     <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_ram_loader.sv
// Directed bench for ram_loader with a behavioural 256-byte RAM downstream.
module tb_ram_loader;

  logic       clk;
  logic       rst_n;
  logic       ack;
  logic       ram_we;
  logic [7:0] ram_addr;
  logic [7:0] ram_din;
  logic       busy;
  logic       done;
  logic       err;

  ram_loader_if sif ();

  ram_loader dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .s        (sif.slave),
    .ack      (ack),
    .ram_we   (ram_we),
    .ram_addr (ram_addr),
    .ram_din  (ram_din),
    .busy     (busy),
    .done     (done),
    .err      (err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Downstream RAM model plus a log of every committed write.
  logic [7:0] mem [256];
  logic [7:0] wl_addr [$];
  logic [7:0] wl_data [$];
  int         wl_cyc  [$];
  int         cyc = 0;

  always @(posedge clk) begin
    if (ram_we) begin
      mem[ram_addr] <= ram_din;
      wl_addr.push_back(ram_addr);
      wl_data.push_back(ram_din);
      wl_cyc.push_back(cyc);
    end
    cyc = cyc + 1;
  end

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present one byte and wait (bounded) until it is accepted; returns at a negedge.
  task automatic send_byte(input logic [7:0] b, input bit gap);
    int t = 0;
    sif.s_valid = 1'b1;
    sif.s_data  = b;
    while (!sif.s_ready && t < 50) begin
      @(negedge clk);
      t++;
    end
    if (t >= 50) check("accept_timeout", 32'(t), 32'd0);
    @(posedge clk);
    @(negedge clk);
    if (gap) begin
      sif.s_valid = 1'b0;
      @(negedge clk);
    end
  endtask

  task automatic send_seq(input logic [7:0] bytes[$], input bit gap);
    foreach (bytes[i]) send_byte(bytes[i], gap);
    sif.s_valid = 1'b0;
  endtask

  task automatic pulse_ack();
    ack = 1'b1;
    @(posedge clk);
    @(negedge clk);
    ack = 1'b0;
  endtask

  task automatic check_writes(input string tag, input int mark, input logic [7:0] addr0,
                              input logic [7:0] exp_data[$], input bit b2b);
    int bad_a = 0;
    int bad_d = 0;
    int bad_c = 0;
    logic [7:0] ea;
    check({tag, "_nwr"}, 32'(wl_addr.size() - mark), 32'(exp_data.size()));
    if (wl_addr.size() - mark == exp_data.size()) begin
      foreach (exp_data[i]) begin
        ea = addr0 + 8'(i);
        if (wl_addr[mark+i] !== ea) bad_a++;
        if (wl_data[mark+i] !== exp_data[i]) bad_d++;
        if (i > 0 && wl_cyc[mark+i] != wl_cyc[mark+i-1] + 1) bad_c++;
      end
    end
    check({tag, "_addr_bad"}, 32'(bad_a), 32'd0);
    check({tag, "_data_bad"}, 32'(bad_d), 32'd0);
    if (b2b) check({tag, "_b2b_bad"}, 32'(bad_c), 32'd0);
  endtask

  task automatic check_reset_outs(input string tag);
    check({tag, "_we"},    32'(ram_we),      32'd0);
    check({tag, "_addr"},  32'(ram_addr),    32'h00);
    check({tag, "_din"},   32'(ram_din),     32'h00);
    check({tag, "_busy"},  32'(busy),        32'd0);
    check({tag, "_done"},  32'(done),        32'd0);
    check({tag, "_err"},   32'(err),         32'd0);
    check({tag, "_ready"}, 32'(sif.s_ready), 32'd1);
  endtask

  initial begin
    logic [7:0] fr[$];
    logic [7:0] pay[$];
    int mark;

    rst_n       = 1'b0;
    ack         = 1'b0;
    sif.s_valid = 1'b0;
    sif.s_data  = 8'h00;
    repeat (2) @(posedge clk);
    @(negedge clk);
    check_reset_outs("rst0");
    rst_n = 1'b1;
    @(negedge clk);

    // Basic frame, checksum 0x87.
    mark = wl_addr.size();
    send_byte(8'hA5, 1'b0);
    check("t1_busy_after_sync", 32'(busy), 32'd1);
    fr = '{8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h87};
    send_seq(fr, 1'b0);
    check("t1_done", 32'(done), 32'd1);
    check("t1_err", 32'(err), 32'd0);
    check("t1_busy", 32'(busy), 32'd0);
    check("t1_ready", 32'(sif.s_ready), 32'd0);
    pay = '{8'h11, 8'h22, 8'h33};
    check_writes("t1", mark, 8'h10, pay, 1'b1);
    check("t1_ram10", 32'(mem[8'h10]), 32'h11);
    check("t1_ram12", 32'(mem[8'h12]), 32'h33);
    check("t1_addr_hold", 32'(ram_addr), 32'h12);
    check("t1_din_hold", 32'(ram_din), 32'h33);
    pulse_ack();
    check("t1_done_clr", 32'(done), 32'd0);
    check("t1_ready_idle", 32'(sif.s_ready), 32'd1);

    // Same frame with a bad checksum.
    mark = wl_addr.size();
    fr = '{8'hA5, 8'h10, 8'h03, 8'h11, 8'h22, 8'h33, 8'h00};
    send_seq(fr, 1'b0);
    check("t2_err", 32'(err), 32'd1);
    check("t2_done", 32'(done), 32'd0);
    check_writes("t2", mark, 8'h10, pay, 1'b1);
    sif.s_valid = 1'b1;
    sif.s_data  = 8'hA5;
    repeat (3) @(negedge clk);
    check("t2_ready_held", 32'(sif.s_ready), 32'd0);
    check("t2_err_held", 32'(err), 32'd1);
    check("t2_no_extra_wr", 32'(wl_addr.size() - mark), 32'd3);
    sif.s_valid = 1'b0;
    pulse_ack();
    check("t2_err_clr", 32'(err), 32'd0);
    check("t2_ready_idle", 32'(sif.s_ready), 32'd1);
    check("t2_busy_idle", 32'(busy), 32'd0);

    // Address wrap FE -> FF -> 00, checksum 0xCE.
    mark = wl_addr.size();
    fr = '{8'hA5, 8'hFE, 8'h03, 8'hAA, 8'hBB, 8'hCC, 8'hCE};
    send_seq(fr, 1'b0);
    check("t3_done", 32'(done), 32'd1);
    pay = '{8'hAA, 8'hBB, 8'hCC};
    check_writes("t3", mark, 8'hFE, pay, 1'b1);
    check("t3_ramFE", 32'(mem[8'hFE]), 32'hAA);
    check("t3_ramFF", 32'(mem[8'hFF]), 32'hBB);
    check("t3_ram00", 32'(mem[8'h00]), 32'hCC);
    pulse_ack();

    // Length 0 means 256 bytes; payload sum 0x7F80 -> checksum 0x80.
    mark = wl_addr.size();
    fr = '{8'hA5, 8'h00, 8'h00};
    pay.delete();
    for (int i = 0; i < 256; i++) begin
      fr.push_back(8'(i));
      pay.push_back(8'(i));
    end
    fr.push_back(8'h80);
    send_seq(fr, 1'b0);
    check("t4_done", 32'(done), 32'd1);
    check("t4_err", 32'(err), 32'd0);
    check_writes("t4", mark, 8'h00, pay, 1'b1);
    begin
      int bad = 0;
      for (int i = 0; i < 256; i++) if (mem[i] !== 8'(i)) bad++;
      check("t4_ram_bad", 32'(bad), 32'd0);
    end
    pulse_ack();

    // Garbage then a gapped frame whose payload contains the sync byte.
    mark = wl_addr.size();
    fr = '{8'h00, 8'hFF, 8'h5A, 8'hA5, 8'h40, 8'h02, 8'hA5, 8'h01, 8'h18};
    send_seq(fr, 1'b1);
    check("t5_done", 32'(done), 32'd1);
    check("t5_err", 32'(err), 32'd0);
    pay = '{8'hA5, 8'h01};
    check_writes("t5", mark, 8'h40, pay, 1'b0);
    check("t5_ram40", 32'(mem[8'h40]), 32'hA5);
    check("t5_ram41", 32'(mem[8'h41]), 32'h01);
    pulse_ack();

    // Reset after 2 of 4 payload bytes.
    mark = wl_addr.size();
    fr = '{8'hA5, 8'h80, 8'h04, 8'h11, 8'h22};
    send_seq(fr, 1'b0);
    rst_n = 1'b0;
    @(posedge clk);
    @(negedge clk);
    check_reset_outs("t6_rst");
    rst_n = 1'b1;
    repeat (2) @(negedge clk);
    pay = '{8'h11, 8'h22};
    check_writes("t6", mark, 8'h80, pay, 1'b1);
    check("t6_ram82", 32'(mem[8'h82]), 32'h82);
    check("t6_ram83", 32'(mem[8'h83]), 32'h83);

    // Next frame after reset loads normally; checksum 0x61.
    mark = wl_addr.size();
    fr = '{8'hA5, 8'h80, 8'h02, 8'h5A, 8'hC3, 8'h61};
    send_seq(fr, 1'b0);
    check("t7_done", 32'(done), 32'd1);
    pay = '{8'h5A, 8'hC3};
    check_writes("t7", mark, 8'h80, pay, 1'b1);
    check("t7_ram80", 32'(mem[8'h80]), 32'h5A);
    check("t7_ram81", 32'(mem[8'h81]), 32'hC3);
    pulse_ack();

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
